// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding and parity mode codes,
// used by both the buffered transmitter and the matching receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } uart_state_e;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'b000,
      PAR_EVEN  = 3'b001,
      PAR_ODD   = 3'b010,
      PAR_MARK  = 3'b011,
      PAR_SPACE = 3'b100
   } parity_e;

   // Reserved codes 101..111 fall back to no parity.
   function automatic parity_e decode_parity(input logic [2:0] mode);
      case (mode)
         3'b001:  return PAR_EVEN;
         3'b010:  return PAR_ODD;
         3'b011:  return PAR_MARK;
         3'b100:  return PAR_SPACE;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with registered full/empty/count flags.
// Push is ignored while full and pop while empty; the head word is always visible.
module sync_fifo #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;
   logic [CNT_W-1:0] w_count_nxt;

   // Full is judged on the registered flag, so a same-cycle pop never makes room.
   assign w_do_push = push && !r_full;
   assign w_do_pop  = pop && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wdata;
   end

   assign rdata = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, runtime data length / parity /
// stop bits latched per frame; frames abut with no idle gap while words are queued.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int MAX_DATA_W = 9,
   parameter  int FIFO_DEPTH = 8,
   parameter  int LEN_W      = $clog2(MAX_DATA_W + 1),
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  baud_clk,
   input  logic                  arst,
   input  logic                  wr_en,
   input  logic [MAX_DATA_W-1:0] wr_data,
   input  logic [LEN_W-1:0]      data_len,
   input  logic [2:0]            parity_mode,
   input  logic                  stop_bits,
   input  logic                  ovf_clr,
   output logic                  tx,
   output logic                  tx_active,
   output logic                  tx_done,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow
);

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      if (len < LEN_W'(5) || len > LEN_W'(MAX_DATA_W)) return LEN_W'(MAX_DATA_W);
      return len;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] mask_word(input logic [MAX_DATA_W-1:0] w,
                                                       input logic [LEN_W-1:0]      len);
      logic [MAX_DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_DATA_W; i++) if (i < int'(len)) m[i] = w[i];
      return m;
   endfunction

   function automatic logic parity_bit(input parity_e mode, input logic [MAX_DATA_W-1:0] w);
      case (mode)
         PAR_EVEN: return ^w;
         PAR_ODD:  return ~^w;
         PAR_MARK: return 1'b1;
         default:  return 1'b0;
      endcase
   endfunction

   uart_state_e           r_state;
   uart_state_e           w_state_nxt;
   logic [MAX_DATA_W-1:0] r_shift;
   logic [MAX_DATA_W-1:0] w_shift_nxt;
   logic [LEN_W-1:0]      r_bit_cnt;
   logic [LEN_W-1:0]      r_len;
   parity_e               r_mode;
   logic                  r_stop2;
   logic                  r_par;
   logic                  r_tx;
   logic                  r_overflow;
   logic                  w_tx_nxt;
   logic                  w_pop;
   logic                  w_final;
   logic [MAX_DATA_W-1:0] w_head;
   logic [LEN_W-1:0]      w_len_cfg;
   parity_e               w_mode_cfg;
   logic [MAX_DATA_W-1:0] w_word_cfg;

   sync_fifo #(
      .WIDTH (MAX_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (baud_clk),
      .arst  (arst),
      .push  (wr_en),
      .pop   (w_pop),
      .wdata (wr_data),
      .rdata (w_head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Configuration as it will be latched if a pop happens this cycle.
   assign w_len_cfg  = clamp_len(data_len);
   assign w_mode_cfg = decode_parity(parity_mode);
   assign w_word_cfg = mask_word(w_head, w_len_cfg);
   assign w_final    = (r_state == ST_STOP2) || (r_state == ST_STOP1 && !r_stop2);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_shift_nxt = r_shift;
      w_tx_nxt    = 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (!empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START:  w_state_nxt = ST_DATA;
         ST_DATA: begin
            w_shift_nxt = r_shift >> 1;
            if (r_bit_cnt == r_len - 1'b1) begin
               if (r_mode != PAR_NONE) w_state_nxt = ST_PARITY;
               else                    w_state_nxt = ST_STOP1;
            end
         end
         ST_PARITY: w_state_nxt = ST_STOP1;
         ST_STOP1:  if (r_stop2) w_state_nxt = ST_STOP2;
         ST_STOP2:  w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
      // Final stop bit chains straight into the next start bit when a word is queued.
      if (w_final) begin
         if (!empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
      if (w_pop) w_shift_nxt = w_word_cfg;
      case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
         ST_PARITY: w_tx_nxt = r_par;
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge baud_clk or posedge arst) begin
      if (arst) begin
         r_state    <= ST_IDLE;
         r_tx       <= 1'b1;
         r_bit_cnt  <= '0;
         r_len      <= LEN_W'(MAX_DATA_W);
         r_mode     <= PAR_NONE;
         r_stop2    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tx      <= w_tx_nxt;
         r_bit_cnt <= (r_state == ST_DATA) ? r_bit_cnt + 1'b1 : '0;
         if (w_pop) begin
            r_len   <= w_len_cfg;
            r_mode  <= w_mode_cfg;
            r_stop2 <= stop_bits;
         end
         if (wr_en && full) r_overflow <= 1'b1;
         else if (ovf_clr)  r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge baud_clk) begin
      r_shift <= w_shift_nxt;
      if (w_pop) r_par <= parity_bit(w_mode_cfg, w_word_cfg);
   end

   assign tx        = r_tx;
   assign tx_active = (r_state != ST_IDLE);
   assign tx_done   = w_final;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: hand-written tx bit strings per frame, FIFO
// fill/overflow ordering, back-to-back framing and asynchronous reset mid-frame.
module tb_uart_tx_fifo;

   logic       baud_clk = 1'b0;
   logic       arst;
   logic       wr_en;
   logic [8:0] wr_data;
   logic [3:0] data_len;
   logic [2:0] parity_mode;
   logic       stop_bits;
   logic       ovf_clr;
   logic       tx;
   logic       tx_active;
   logic       tx_done;
   logic       full;
   logic       empty;
   logic [3:0] fifo_count;
   logic       overflow;

   int n_chk  = 0;
   int n_pass = 0;

   logic [8:0]  rx_q [$];
   logic [15:0] mon_bits;
   int          mon_pos = 0;
   logic [8:0]  words [10];

   uart_tx_fifo #(
      .MAX_DATA_W (9),
      .FIFO_DEPTH (8)
   ) dut (
      .baud_clk    (baud_clk),
      .arst        (arst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .data_len    (data_len),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .ovf_clr     (ovf_clr),
      .tx          (tx),
      .tx_active   (tx_active),
      .tx_done     (tx_done),
      .full        (full),
      .empty       (empty),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   always #5 baud_clk = ~baud_clk;

   // Frame capture: data bits sit in frame cycles 1..9 for a 9-bit configuration.
   always @(negedge baud_clk) begin
      if (arst) begin
         mon_pos = 0;
      end else if (tx_active) begin
         if (mon_pos < 16) mon_bits[mon_pos] = tx;
         mon_pos++;
         if (tx_done) begin
            rx_q.push_back(mon_bits[9:1]);
            mon_pos = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge baud_clk);
      #1;
   endtask

   task automatic write_word(input logic [8:0] w);
      wr_data = w;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   // s[i] is the expected tx value in frame cycle i; entry assumes cycle start-1 is current.
   task automatic check_frame(input string tag, input string s, input int start);
      for (int i = start; i < s.len(); i++) begin
         step();
         chk($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(s[i] == 8'h31));
         chk($sformatf("%s_act%0d", tag, i), 32'(tx_active), 32'(1));
         chk($sformatf("%s_done%0d", tag, i), 32'(tx_done), 32'(i == s.len() - 1));
      end
   endtask

   task automatic idle_check(input string tag);
      step();
      chk({tag, "_idle_tx"}, 32'(tx), 32'(1));
      chk({tag, "_idle_act"}, 32'(tx_active), 32'(0));
   endtask

   task automatic set_cfg(input logic [3:0] len, input logic [2:0] pm, input logic sb);
      data_len    = len;
      parity_mode = pm;
      stop_bits   = sb;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
      set_cfg(4'd8, 3'b000, 1'b0);
      step(); step();
      chk("rst_tx", 32'(tx), 32'(1));
      chk("rst_act", 32'(tx_active), 32'(0));
      chk("rst_done", 32'(tx_done), 32'(0));
      chk("rst_full", 32'(full), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_cnt", 32'(fifo_count), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      arst = 1'b0;
      step();
      chk("idle_tx", 32'(tx), 32'(1));

      // 0xD5, 8 bits, even parity, two stops
      set_cfg(4'd8, 3'b001, 1'b1);
      write_word(9'h0D5);
      chk("even2_cnt", 32'(fifo_count), 32'(1));
      chk("even2_empty", 32'(empty), 32'(0));
      check_frame("even2", "010101011111", 0);
      idle_check("even2");

      set_cfg(4'd8, 3'b010, 1'b0);
      write_word(9'h0D5);
      check_frame("odd1", "01010101101", 0);
      idle_check("odd1");

      // Mark mode, with config scrambled after the frame has latched its settings
      set_cfg(4'd8, 3'b011, 1'b0);
      write_word(9'h0D5);
      step();
      chk("mark1_tx0", 32'(tx), 32'(0));
      set_cfg(4'd5, 3'b000, 1'b1);
      check_frame("mark1", "01010101111", 1);
      idle_check("mark1");

      set_cfg(4'd8, 3'b100, 1'b0);
      write_word(9'h0D5);
      check_frame("space1", "01010101101", 0);
      idle_check("space1");

      set_cfg(4'd5, 3'b000, 1'b0);
      write_word(9'h1F3);
      check_frame("len5", "0110011", 0);
      idle_check("len5");

      set_cfg(4'd12, 3'b000, 1'b0);
      write_word(9'h1F3);
      check_frame("clamp", "01100111111", 0);
      idle_check("clamp");

      // Three writes in consecutive cycles
      set_cfg(4'd5, 3'b000, 1'b0);
      wr_data = 9'h001; wr_en = 1'b1;
      step();
      wr_data = 9'h002;
      step();
      chk("b2b_a_tx0", 32'(tx), 32'(0));
      wr_data = 9'h003;
      step();
      chk("b2b_a_tx1", 32'(tx), 32'(1));
      wr_en = 1'b0;
      check_frame("b2b_a", "0100001", 2);
      check_frame("b2b_b", "0010001", 0);
      check_frame("b2b_c", "0110001", 0);
      idle_check("b2b");

      // Overflow: 13-cycle frames keep the first pop busy while the FIFO fills
      set_cfg(4'd9, 3'b001, 1'b1);
      rx_q.delete();
      for (int k = 0; k < 9; k++) words[k] = 9'(k * 53 + 17);
      words[9] = 9'h1AA;
      for (int k = 0; k < 10; k++) begin
         wr_data = words[k];
         wr_en   = 1'b1;
         step();
         if (k == 8) begin
            chk("fill_full", 32'(full), 32'(1));
            chk("fill_cnt", 32'(fifo_count), 32'(8));
            chk("fill_noovf", 32'(overflow), 32'(0));
         end
      end
      chk("ovf_set", 32'(overflow), 32'(1));
      chk("ovf_cnt", 32'(fifo_count), 32'(8));
      wr_data = 9'h155; ovf_clr = 1'b1;
      step();
      chk("ovf_setwins", 32'(overflow), 32'(1));
      wr_en = 1'b0;
      step();
      chk("ovf_clr", 32'(overflow), 32'(0));
      ovf_clr = 1'b0;
      for (int c = 0; c < 200 && rx_q.size() < 9; c++) step();
      chk("ovf_frames", 32'(rx_q.size()), 32'(9));
      for (int k = 0; k < 9; k++)
         chk($sformatf("ovf_word%0d", k),
             (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hFFFF_FFFF, 32'(words[k]));
      step();
      chk("ovf_drain_empty", 32'(empty), 32'(1));
      chk("ovf_drain_act", 32'(tx_active), 32'(0));
      step();
      chk("ovf_drain_frames", 32'(rx_q.size()), 32'(9));

      // Asynchronous reset in the middle of DATA, while tx is low
      set_cfg(4'd8, 3'b001, 1'b1);
      wr_data = 9'h0D5; wr_en = 1'b1;
      step();
      wr_data = 9'h055;
      step();
      wr_data = 9'h0AA;
      step();
      wr_en = 1'b0;
      step();
      chk("arst_pre_tx", 32'(tx), 32'(0));
      chk("arst_pre_cnt", 32'(fifo_count), 32'(2));
      arst = 1'b1;
      #1;
      chk("arst_tx", 32'(tx), 32'(1));
      chk("arst_cnt", 32'(fifo_count), 32'(0));
      chk("arst_empty", 32'(empty), 32'(1));
      chk("arst_act", 32'(tx_active), 32'(0));
      step(); step();
      arst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         chk($sformatf("post_rst_tx%0d", c), 32'(tx), 32'(1));
         chk($sformatf("post_rst_act%0d", c), 32'(tx_active), 32'(0));
      end
      set_cfg(4'd5, 3'b000, 1'b0);
      write_word(9'h1F3);
      check_frame("post_rst", "0110011", 0);
      idle_check("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter for the UART project. It accepts words through a write-strobe FIFO interface and serialises them LSB-first with runtime-selectable data length, parity mode and stop-bit count. Back-to-back frames go out with no idle gap while the FIFO holds data. It sits between the host/register logic and the `tx` pin, one bit per `baud_clk` cycle, and supersedes the unbuffered fixed-format serialiser.

## Interface
- `MAX_DATA_W`, 9: widest supported data field; runtime length range 5..MAX_DATA_W.
- `FIFO_DEPTH`, 8: word buffer depth; power of two, ≥2.
- `LEN_W`, $clog2(MAX_DATA_W+1): width of `data_len`.

Clock and reset:
- `baud_clk` in 1: single clock, one serial bit per cycle.
- `arst` in 1: asynchronous, active-high reset.

Write and configuration:
- `wr_en` in 1: write strobe; accepted when `full`=0.
- `wr_data` in MAX_DATA_W: word to send; bits above `data_len` ignored.
- `data_len` in LEN_W: data bits per frame; values outside 5..MAX_DATA_W are clamped to MAX_DATA_W.
- `parity_mode` in 3: 000 none, 001 even, 010 odd, 011 mark (1), 100 space (0); 101–111 treated as none.
- `stop_bits` in 1: 0 = one stop bit, 1 = two.
- `ovf_clr` in 1: clears `overflow`.

Outputs:
- `tx` out 1: serial line, idle high, registered.
- `tx_active` out 1: high from start bit through final stop bit.
- `tx_done` out 1: one-cycle pulse during the final stop bit of each frame.
- `full` out 1: FIFO full.
- `empty` out 1: FIFO empty.
- `fifo_count` out $clog2(FIFO_DEPTH+1): occupancy.
- `overflow` out 1: sticky; set by `wr_en` while `full`.

## Operation
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0], shifts right each cycle.
  - PARITY: `tx`=computed parity bit.
  - STOP1 and STOP2: `tx`=1.
- IDLE→START: on any edge with FIFO non-empty. Pop the head word into the shift register and latch `data_len`, `parity_mode` and `stop_bits` for the whole frame. Config changes mid-frame have no effect.
- START→DATA: unconditional.
- DATA: runs for exactly the latched length, using a bit counter from 0 to len-1. Then go to PARITY if the mode is not none, else STOP1.
- PARITY→STOP1: unconditional.
- Parity values:
  - Even: XOR of the len data bits.
  - Odd: inverted XOR.
  - Mark: 1.
  - Space: 0.
- STOP1: if two stop bits, go to STOP2; otherwise this is the final stop.
- Final stop bit:
  - Assert `tx_done`.
  - If FIFO non-empty: pop, latch config, go to START (no idle cycle).
  - Otherwise go to IDLE.
- Frame length in cycles = 1 + len + (parity≠none) + (1 or 2).
- FIFO write:
  - Accepted when `wr_en` && !`full`; the word is stored at the edge.
  - `wr_en` while `full`: word dropped, `overflow` set.
  - A pop in the same cycle does not make room; full is evaluated before the edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- `ovf_clr` and an overflow event in the same cycle: set wins.

## Timing
- Reset values:
  - `tx`=1, `tx_active`=0, `tx_done`=0.
  - `full`=0, `empty`=1, `fifo_count`=0, `overflow`=0.
  - FSM in IDLE; FIFO pointers at 0.
- Reset mid-frame: `tx` goes high immediately and asynchronously, and the FIFO contents are discarded.
- Latency: a write accepted at edge N with the FSM in IDLE and FIFO empty gives pop and START at edge N+1. `tx` is low from edge N+1 for one cycle.
- `tx_active` rises with START and falls at the edge leaving the final stop. It stays high across back-to-back frames.
- `full`, `empty` and `fifo_count` are registered and valid the cycle after the push or pop edge.

## Structure
- Shared package `uart_pkg`: state encoding (IDLE, START, DATA, PARITY, STOP1, STOP2) and the `parity_mode` codes, both reused by the matching receiver.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): push/pop, `full`, `empty`, `count`. The FSM and shifter stay in the top module.

## Test plan
- Reset, then write 0x0D5 with len=8, even parity, two stop bits. `tx` sequence: 0,1,0,1,0,1,0,1,1,1,1,1 (parity 1). `tx_done` pulses in cycle 12.
- Same word with odd parity and one stop bit: parity bit 0, 11-cycle frame. Then mark and space modes: parity bit 1 and 0 respectively.
- len=5, no parity, write 0x1F3. Only bits 1,1,0,0,1 are sent after the start bit, 7-cycle frame. len=12 clamps to 9.
- Write 3 words in consecutive cycles. Frames abut with no idle cycle, `tx_active` stays high throughout, and `tx_done` pulses 3 times.
- Fill FIFO_DEPTH+1 words while `tx` is busy. `full`=1, the extra word is dropped and `overflow`=1. `ovf_clr` clears it, and exactly FIFO_DEPTH(+1 popped) frames go out in order.
- Assert `arst` in the middle of DATA. `tx`=1 immediately and `fifo_count`=0. After release, nothing is sent until a new write.
